// File: rtl/error_trap_ctrl_pkg.sv
// Shared definitions for the CPU error trap path: error codes and trap FSM encoding.
// Pure declarations, no logic.
// Error codes are shared with the upstream error-code combiner.
package error_trap_ctrl_pkg;

  // CPU error codes produced by the combiner; 4..15 are reserved but still trap.
  localparam logic [3:0] NO_ERROR       = 4'd0;
  localparam logic [3:0] DIV_BY_ZERO    = 4'd1;
  localparam logic [3:0] MEM_ACCESS_ERR = 4'd2;
  localparam logic [3:0] IS_OPCODE_ERR  = 4'd3;

  // Trap controller state encoding.
  typedef enum logic [1:0] {
    RUN     = 2'd0,
    HALTED  = 2'd1,
    RECOVER = 2'd2
  } trap_state_t;

endpackage

// File: rtl/error_trap_ctrl_if.sv
// Bundle between the error combiner / PCU side and the trap controller.
// No logic, no latency.
// No backpressure: the combiner presents a code every cycle; the PCU acknowledges with err_clr.
interface error_trap_ctrl_if #(
  parameter int PC_WIDTH  = 32,
  parameter int CNT_WIDTH = 8
);

  logic [3:0]           cpu_error;
  logic [PC_WIDTH-1:0]  cur_pc;
  logic                 err_clr;
  logic                 cnt_clr;
  logic                 cpu_halt;
  logic                 err_pending;
  logic [3:0]           err_code;
  logic [PC_WIDTH-1:0]  err_pc;
  logic [CNT_WIDTH-1:0] err_cnt;
  logic                 err_lost;
  logic                 flush;

  // Driver side: combiner/PCU inputs, status outputs observed.
  modport master (
    output cpu_error, cur_pc, err_clr, cnt_clr,
    input  cpu_halt, err_pending, err_code, err_pc, err_cnt, err_lost, flush
  );

  // Trap controller side.
  modport slave (
    input  cpu_error, cur_pc, err_clr, cnt_clr,
    output cpu_halt, err_pending, err_code, err_pc, err_cnt, err_lost, flush
  );

endinterface

// File: rtl/error_trap_ctrl.sv
// Traps the first non-zero CPU error code, halts the core until the PCU acknowledges, then flushes and recovers.
// Latency: cpu_halt/err_pending rise one cycle after the error is sampled; all outputs registered.
// Backpressure: none on the error input; further errors while not in RUN only set the sticky err_lost flag.
module error_trap_ctrl
  import error_trap_ctrl_pkg::*;
#(
  parameter int PC_WIDTH       = 32,
  parameter int CNT_WIDTH      = 8,
  parameter int RECOVER_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rstn,
  error_trap_ctrl_if.slave    bus
);

  // Recover counter loads RECOVER_CYCLES-1 and leaves RECOVER once it reads zero.
  localparam logic [3:0] RC_LOAD = 4'(RECOVER_CYCLES - 1);

  trap_state_t          r_state;
  logic                 r_halt;
  logic                 r_pending;
  logic                 r_flush;
  logic                 r_lost;
  logic [3:0]           r_code;
  logic [PC_WIDTH-1:0]  r_pc;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [3:0]           r_rcnt;

  logic                 w_err;
  logic                 w_accept;
  logic [CNT_WIDTH-1:0] w_cnt_base;
  logic [CNT_WIDTH-1:0] w_cnt_next;

  assign w_err    = (bus.cpu_error != NO_ERROR);
  assign w_accept = (r_state == RUN) && w_err;

  // Saturating trap counter: clear first, then count an accepted trap.
  always_comb begin
    w_cnt_base = bus.cnt_clr ? '0 : r_cnt;
    w_cnt_next = w_cnt_base;
    if (w_accept && (w_cnt_base != '1)) begin
      w_cnt_next = w_cnt_base + CNT_WIDTH'(1);
    end
  end

  // Trap FSM with registered outputs, captured code/PC and sticky lost flag.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= RUN;
      r_halt    <= 1'b0;
      r_pending <= 1'b0;
      r_flush   <= 1'b0;
      r_lost    <= 1'b0;
      r_code    <= '0;
      r_pc      <= '0;
      r_cnt     <= '0;
      r_rcnt    <= '0;
    end else begin
      r_cnt <= w_cnt_next;
      case (r_state)
        RUN: begin
          // err_clr is meaningless here; a coincident error still traps.
          if (w_err) begin
            r_state   <= HALTED;
            r_halt    <= 1'b1;
            r_pending <= 1'b1;
            r_code    <= bus.cpu_error;
            r_pc      <= bus.cur_pc;
          end
        end
        HALTED: begin
          if (bus.err_clr) begin
            r_state   <= RECOVER;
            r_pending <= 1'b0;
            r_flush   <= 1'b1;
            r_rcnt    <= RC_LOAD;
            // Acknowledge clears err_lost unless an error lands on this very edge.
            r_lost    <= w_err;
          end else if (w_err) begin
            r_lost <= 1'b1;
          end
        end
        RECOVER: begin
          // flush only marks the first RECOVER cycle; a still-high err_clr is ignored.
          r_flush <= 1'b0;
          if (w_err) begin
            r_lost <= 1'b1;
          end
          if (r_rcnt == 4'd0) begin
            r_state <= RUN;
            r_halt  <= 1'b0;
          end else begin
            r_rcnt <= r_rcnt - 4'd1;
          end
        end
        default: begin
          r_state   <= RUN;
          r_halt    <= 1'b0;
          r_pending <= 1'b0;
          r_flush   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cpu_halt    = r_halt;
  assign bus.err_pending = r_pending;
  assign bus.flush       = r_flush;
  assign bus.err_lost    = r_lost;
  assign bus.err_code    = r_code;
  assign bus.err_pc      = r_pc;
  assign bus.err_cnt     = r_cnt;

endmodule

// File: tb/tb_error_trap_ctrl.sv
// Self-checking bench for error_trap_ctrl with CNT_WIDTH=2 and RECOVER_CYCLES=2.
// Expected traps are queued when the error is driven and compared when err_pending rises.
// Inputs are driven and outputs sampled 1ns after each rising edge.
module tb_error_trap_ctrl;

  localparam int PCW = 32;
  localparam int CW  = 2;
  localparam int RC  = 2;

  typedef struct packed {
    logic [3:0]     code;
    logic [PCW-1:0] pc;
    logic [CW-1:0]  cnt;
  } exp_t;

  logic clk;
  logic rstn;
  int   checks;
  int   errors;
  int   mcnt;
  exp_t sb[$];

  error_trap_ctrl_if #(.PC_WIDTH(PCW), .CNT_WIDTH(CW)) bus();

  error_trap_ctrl #(
    .PC_WIDTH(PCW), .CNT_WIDTH(CW), .RECOVER_CYCLES(RC)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one trap in RUN; the scoreboard entry is compared when err_pending rises.
  task automatic do_trap(input logic [3:0] code, input logic [PCW-1:0] pc, input bit with_clr);
    exp_t e;
    exp_t g;
    int   n;
    if (with_clr) mcnt = 0;
    mcnt = (mcnt == 3) ? 3 : mcnt + 1;
    e.code = code;
    e.pc   = pc;
    e.cnt  = CW'(mcnt);
    sb.push_back(e);
    bus.cpu_error = code;
    bus.cur_pc    = pc;
    bus.cnt_clr   = with_clr;
    tick();
    bus.cpu_error = 4'd0;
    bus.cnt_clr   = 1'b0;
    n = 0;
    while (bus.err_pending !== 1'b1 && n < 4) begin
      tick();
      n++;
    end
    checks++;
    if (bus.err_pending !== 1'b1 || n != 0) begin
      $display("FAIL trap_latency: pending=%b after %0d extra cycles, required 1 after 0", bus.err_pending, n);
      errors++;
    end
    if (sb.size() > 0) begin
      g = sb.pop_front();
      checks++;
      if (bus.err_code !== g.code) begin
        $display("FAIL trap_code: got %0h required %0h", bus.err_code, g.code);
        errors++;
      end
      checks++;
      if (bus.err_pc !== g.pc) begin
        $display("FAIL trap_pc: got %08h required %08h", bus.err_pc, g.pc);
        errors++;
      end
      checks++;
      if (bus.err_cnt !== g.cnt) begin
        $display("FAIL trap_cnt: got %0d required %0d", bus.err_cnt, g.cnt);
        errors++;
      end
    end
    checks++;
    if (bus.cpu_halt !== 1'b1) begin
      $display("FAIL trap_halt: got %b required 1", bus.cpu_halt);
      errors++;
    end
  endtask

  // Tick until cpu_halt drops, bounded.
  task automatic wait_run();
    int n;
    n = 0;
    while (bus.cpu_halt !== 1'b0 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (bus.cpu_halt !== 1'b0) begin
      $display("FAIL wait_run: cpu_halt still %b after %0d cycles", bus.cpu_halt, n);
      errors++;
    end
  endtask

  // One-cycle acknowledge with exact flush/halt timing.
  task automatic do_release();
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    checks++;
    if (bus.flush !== 1'b1 || bus.cpu_halt !== 1'b1 || bus.err_pending !== 1'b0) begin
      $display("FAIL release_entry: flush=%b halt=%b pending=%b required 1 1 0", bus.flush, bus.cpu_halt, bus.err_pending);
      errors++;
    end
    for (int i = 1; i < RC; i++) begin
      tick();
      checks++;
      if (bus.flush !== 1'b0 || bus.cpu_halt !== 1'b1) begin
        $display("FAIL release_hold: cycle %0d flush=%b halt=%b required 0 1", i, bus.flush, bus.cpu_halt);
        errors++;
      end
    end
    tick();
    checks++;
    if (bus.cpu_halt !== 1'b0 || bus.flush !== 1'b0) begin
      $display("FAIL release_exit: halt=%b flush=%b required 0 0", bus.cpu_halt, bus.flush);
      errors++;
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    bus.cpu_error = 4'd0;
    bus.cur_pc = '0;
    bus.err_clr = 1'b0;
    bus.cnt_clr = 1'b0;
    mcnt = 0;
    repeat (3) tick();
    rstn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if ({bus.cpu_halt, bus.err_pending, bus.flush, bus.err_lost} !== 4'b0 ||
          bus.err_code !== 4'd0 || bus.err_pc !== '0 || bus.err_cnt !== '0) begin
        $display("FAIL reset_idle: cycle %0d halt=%b pend=%b flush=%b lost=%b code=%0h pc=%08h cnt=%0d required all 0",
                 i, bus.cpu_halt, bus.err_pending, bus.flush, bus.err_lost, bus.err_code, bus.err_pc, bus.err_cnt);
        errors++;
      end
    end
  endtask

  task automatic test_single_trap_release();
    do_trap(4'd2, 32'h0000_1040, 1'b0);
    do_release();
    checks++;
    if (bus.err_code !== 4'd2 || bus.err_pc !== 32'h0000_1040) begin
      $display("FAIL hold_after_run: code=%0h pc=%08h required 2 00001040", bus.err_code, bus.err_pc);
      errors++;
    end
  endtask

  task automatic test_lost();
    do_trap(4'd2, 32'h0000_2000, 1'b0);
    bus.cpu_error = 4'd3;
    tick();
    bus.cpu_error = 4'd0;
    checks++;
    if (bus.err_lost !== 1'b1 || bus.err_code !== 4'd2 || bus.err_cnt !== CW'(mcnt) || bus.err_pending !== 1'b1) begin
      $display("FAIL lost_set: lost=%b code=%0h cnt=%0d pend=%b required 1 2 %0d 1", bus.err_lost, bus.err_code, bus.err_cnt, bus.err_pending, mcnt);
      errors++;
    end
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    checks++;
    if (bus.err_lost !== 1'b0 || bus.flush !== 1'b1) begin
      $display("FAIL lost_clear: lost=%b flush=%b required 0 1", bus.err_lost, bus.flush);
      errors++;
    end
    wait_run();
    // Error arriving on the acknowledge edge: set wins.
    do_trap(4'd1, 32'h0000_3000, 1'b0);
    bus.err_clr = 1'b1;
    bus.cpu_error = 4'd1;
    tick();
    bus.err_clr = 1'b0;
    bus.cpu_error = 4'd0;
    checks++;
    if (bus.err_lost !== 1'b1 || bus.err_cnt !== CW'(mcnt) || bus.err_code !== 4'd1) begin
      $display("FAIL lost_set_wins: lost=%b cnt=%0d code=%0h required 1 %0d 1", bus.err_lost, bus.err_cnt, bus.err_code, mcnt);
      errors++;
    end
    wait_run();
  endtask

  task automatic test_clr_held();
    do_trap(4'hF, 32'h0000_4000, 1'b0);
    bus.err_clr = 1'b1;
    tick();
    checks++;
    if (bus.flush !== 1'b1 || bus.err_lost !== 1'b0) begin
      $display("FAIL held_entry: flush=%b lost=%b required 1 0", bus.flush, bus.err_lost);
      errors++;
    end
    tick();
    checks++;
    if (bus.flush !== 1'b0 || bus.cpu_halt !== 1'b1) begin
      $display("FAIL held_single_flush: flush=%b halt=%b required 0 1", bus.flush, bus.cpu_halt);
      errors++;
    end
    tick();
    checks++;
    if (bus.cpu_halt !== 1'b0) begin
      $display("FAIL held_exit: halt=%b required 0", bus.cpu_halt);
      errors++;
    end
    tick();
    checks++;
    if (bus.cpu_halt !== 1'b0 || bus.flush !== 1'b0) begin
      $display("FAIL held_run_ignore: halt=%b flush=%b required 0 0", bus.cpu_halt, bus.flush);
      errors++;
    end
    // Error together with err_clr in RUN traps anyway.
    do_trap(4'd3, 32'h0000_4444, 1'b0);
    bus.err_clr = 1'b0;
    do_release();
  endtask

  task automatic test_saturation();
    bus.cnt_clr = 1'b1;
    tick();
    bus.cnt_clr = 1'b0;
    mcnt = 0;
    checks++;
    if (bus.err_cnt !== '0) begin
      $display("FAIL cnt_clr: got %0d required 0", bus.err_cnt);
      errors++;
    end
    for (int i = 0; i < 4; i++) begin
      do_trap(4'(i + 1), 32'h0000_5000 + 32'(i), 1'b0);
      do_release();
    end
    do_trap(4'd2, 32'h0000_5555, 1'b1);
    do_release();
  endtask

  task automatic test_back_to_back();
    do_trap(4'd1, 32'h0000_6000, 1'b0);
    do_release();
    do_trap(4'd7, 32'h0000_6004, 1'b0);
    do_release();
  endtask

  task automatic test_async_reset();
    do_trap(4'd2, 32'h0000_7000, 1'b0);
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    #2;
    rstn = 1'b0;
    #1;
    checks++;
    if ({bus.cpu_halt, bus.err_pending, bus.flush, bus.err_lost} !== 4'b0 ||
        bus.err_code !== 4'd0 || bus.err_cnt !== '0 || bus.err_pc !== '0) begin
      $display("FAIL async_reset: halt=%b pend=%b flush=%b lost=%b code=%0h cnt=%0d required all 0",
               bus.cpu_halt, bus.err_pending, bus.flush, bus.err_lost, bus.err_code, bus.err_cnt);
      errors++;
    end
    mcnt = 0;
    @(negedge clk);
    rstn = 1'b1;
    tick();
    checks++;
    if (bus.flush !== 1'b0 || bus.cpu_halt !== 1'b0) begin
      $display("FAIL post_reset: flush=%b halt=%b required 0 0", bus.flush, bus.cpu_halt);
      errors++;
    end
    do_trap(4'd1, 32'h0000_8000, 1'b0);
    do_release();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single_trap_release();
    test_lost();
    test_clr_held();
    test_saturation();
    test_back_to_back();
    test_async_reset();
    checks++;
    if (sb.size() != 0) begin
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
      errors++;
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
